// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard sequencer bundle: ID/EX/MEM hazard sources in, pipeline enables/clears and perf counters out.
// The pipeline side is the master and drives the hazard sources; the sequencer is the slave.
interface pipeline_hazard_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           id_rs_i;
  logic [4:0]           id_rt_i;
  logic                 id_uses_rt_i;
  logic                 ex_mem_read_i;
  logic [4:0]           ex_rt_i;
  logic                 mem_redirect_i;
  logic                 ext_hold_i;
  logic                 pc_write_o;
  logic                 if_id_write_o;
  logic                 id_ex_bubble_o;
  logic                 pipe_en_o;
  logic                 if_id_flush_o;
  logic                 id_ex_flush_o;
  logic                 ex_mem_flush_o;
  logic [1:0]           state_o;
  logic [CNT_WIDTH-1:0] stall_count_o;
  logic [CNT_WIDTH-1:0] flush_count_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i, mem_redirect_i, ext_hold_i,
    input  pc_write_o, if_id_write_o, id_ex_bubble_o, pipe_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, state_o, stall_count_o, flush_count_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i, mem_redirect_i, ext_hold_i,
    output pc_write_o, if_id_write_o, id_ex_bubble_o, pipe_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, state_o, stall_count_o, flush_count_o
  );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline; enables/clears are combinational (zero latency).
// ext_hold_i freezes the whole pipe; perf counters exist only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_sequencer #(
  parameter int SHADOW_CYCLES = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  pipeline_hazard_sequencer_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SHADOW = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int SH_W = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);

  state_t          state;
  logic [SH_W-1:0] shadow_cnt;

  logic lu;
  logic hold;
  logic in_shadow;
  logic accept;
  logic stall;

  assign lu = hz.ex_mem_read_i && (hz.ex_rt_i != 5'd0) &&
              ((hz.ex_rt_i == hz.id_rs_i) || (hz.id_uses_rt_i && (hz.ex_rt_i == hz.id_rt_i)));

  assign hold      = hz.ext_hold_i;
  assign in_shadow = (state == ST_SHADOW);
  assign accept    = hz.mem_redirect_i && !hold && !in_shadow;
  assign stall     = lu && !hold && !accept;

  assign hz.pc_write_o     = !(hold || stall);
  assign hz.if_id_write_o  = !(hold || stall);
  assign hz.id_ex_bubble_o = stall;
  assign hz.pipe_en_o      = !hold;
  assign hz.if_id_flush_o  = accept;
  assign hz.id_ex_flush_o  = accept;
  assign hz.ex_mem_flush_o = accept;
  assign hz.state_o        = state;

  // A held MEM redirect re-presents after release, so HOLD simply falls back into normal evaluation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      shadow_cnt <= '0;
    end else if (hold) begin
      if (!in_shadow) state <= ST_HOLD;
    end else if (accept) begin
      state      <= ST_SHADOW;
      shadow_cnt <= SH_W'(SHADOW_CYCLES);
    end else if (in_shadow) begin
      if (shadow_cnt <= SH_W'(1)) begin
        state      <= ST_RUN;
        shadow_cnt <= '0;
      end else begin
        shadow_cnt <= shadow_cnt - SH_W'(1);
      end
    end else begin
      state <= stall ? ST_STALL : ST_RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // Saturating: a pegged counter is more useful to software than a wrapped one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))  stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (accept && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign hz.stall_count_o = stall_cnt;
  assign hz.flush_count_o = flush_cnt;
`else
  assign hz.stall_count_o = '0;
  assign hz.flush_count_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Randomized bench for pipeline_hazard_sequencer against an event-level reference model.
module tb_pipeline_hazard_sequencer;

  localparam int SHC = 3;
  localparam int CW  = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic reset;

  pipeline_hazard_sequencer_if #(.CNT_WIDTH(CW)) hz ();

  pipeline_hazard_sequencer #(.SHADOW_CYCLES(SHC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of redirect shadow left, what the last non-shadow cycle did, event tallies.
  int m_shadow;
  int m_last;
  int m_stalls;
  int m_flushes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_shadow  = 0;
    m_last    = 0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic idle_inputs();
    hz.id_rs_i        = 5'd0;
    hz.id_rt_i        = 5'd0;
    hz.id_uses_rt_i   = 1'b0;
    hz.ex_mem_read_i  = 1'b0;
    hz.ex_rt_i        = 5'd0;
    hz.mem_redirect_i = 1'b0;
    hz.ext_hold_i     = 1'b0;
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                      input logic ld, input logic [4:0] ert, input logic redir, input logic hold);
    logic lu, acc, stl;
    int   st;
    @(negedge clk);
    hz.id_rs_i        = rs;
    hz.id_rt_i        = rt;
    hz.id_uses_rt_i   = uses;
    hz.ex_mem_read_i  = ld;
    hz.ex_rt_i        = ert;
    hz.mem_redirect_i = redir;
    hz.ext_hold_i     = hold;
    #1;
    lu  = ld && (ert != 5'd0) && ((ert == rs) || (uses && (ert == rt)));
    acc = redir && !hold && (m_shadow == 0);
    stl = lu && !hold && !acc;
    st  = (m_shadow > 0) ? 2 : m_last;
    chk("pc_write",    32'(hz.pc_write_o),     32'(!(hold || stl)));
    chk("if_id_write", 32'(hz.if_id_write_o),  32'(!(hold || stl)));
    chk("bubble",      32'(hz.id_ex_bubble_o), 32'(stl));
    chk("pipe_en",     32'(hz.pipe_en_o),      32'(!hold));
    chk("if_id_flush", 32'(hz.if_id_flush_o),  32'(acc));
    chk("id_ex_flush", 32'(hz.id_ex_flush_o),  32'(acc));
    chk("ex_mem_flush",32'(hz.ex_mem_flush_o), 32'(acc));
    chk("state",       32'(hz.state_o),        32'(st));
    chk("stall_count", 32'(hz.stall_count_o),  32'(exp_cnt(m_stalls)));
    chk("flush_count", 32'(hz.flush_count_o),  32'(exp_cnt(m_flushes)));
    @(posedge clk);
    if (hold) begin
      if (m_shadow == 0) m_last = 3;
    end else if (acc) begin
      m_shadow = SHC;
      if (m_flushes < CNT_MAX) m_flushes++;
    end else begin
      if (stl && m_stalls < CNT_MAX) m_stalls++;
      if (m_shadow > 0) begin
        m_shadow--;
        m_last = 0;
      end else begin
        m_last = stl ? 1 : 0;
      end
    end
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_state",       32'(hz.state_o),       32'd0);
    chk("rst_stall_count", 32'(hz.stall_count_o), 32'd0);
    chk("rst_flush_count", 32'(hz.flush_count_o), 32'd0);
    chk("rst_no_flush",    32'(hz.ex_mem_flush_o), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Load-use on rs, then the STALL cycle returns to RUN.
    step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    idle();
    chk("lu_stall_count", 32'(hz.stall_count_o), 32'(exp_cnt(1)));

    // $zero destination and unused rt never stall.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    step(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    idle();

    // Redirect, a second redirect ignored in shadow cycle 2, then back to RUN.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    idle();
    chk("shadow_flush_count", 32'(hz.flush_count_o), 32'(exp_cnt(1)));

    // Redirect together with load-use: flush wins, no bubble.
    step(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    repeat (3) idle();

    // Hold over a pending redirect, accepted on release; then hold inside shadow.
    repeat (4) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    repeat (4) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    repeat (3) idle();
    chk("hold_flush_count", 32'(hz.flush_count_o), 32'(exp_cnt(3)));

    // Saturation: five back-to-back load-use stalls on a 2-bit counter.
    do_reset();
    repeat (5) step(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    idle();
    chk("sat_stall_count", 32'(hz.stall_count_o), 32'(exp_cnt(3)));

    // Reset mid-shadow.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    do_reset();
    idle();

    for (int i = 0; i < 2000; i++) begin
      logic [4:0] rs, rt, ert;
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      ert = 5'($urandom_range(0, 3));
      step(rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ert,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Central stall/flush controller for the 5-stage pipelined MIPS core. It sequences PC/IF-ID write enables, ID/EX control bubbling, and IF/ID, ID/EX and EX/MEM flushes for three cases: load-use hazards, branch/jump/jr redirects resolved in MEM, and an external freeze request. It replaces the stateless hazard detector plus the unimplemented flush outputs. It sits beside the forwarding unit and drives the pipeline register enables and clears.

Parameters:
SHADOW_CYCLES, 3, cycles after an accepted redirect during which further redirects are ignored (bubbles draining to MEM)
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs_i  in  5  rs field of the instruction in ID
id_rt_i  in  5  rt field of the instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt as a source
ex_mem_read_i  in  1  instruction in EX is a load
ex_rt_i  in  5  destination rt of the load in EX
mem_redirect_i  in  1  taken branch, jump or jr in MEM (PC mux selects target)
ext_hold_i  in  1  external freeze request, e.g. memory busy
pc_write_o  out  1  PC load enable
if_id_write_o  out  1  IF/ID load enable
id_ex_bubble_o  out  1  zero the 11 control bits entering ID/EX
pipe_en_o  out  1  load enable for ID/EX, EX/MEM, MEM/WB
if_id_flush_o  out  1  synchronous clear of IF/ID
id_ex_flush_o  out  1  synchronous clear of ID/EX
ex_mem_flush_o  out  1  synchronous clear of EX/MEM
state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 SHADOW, 3 HOLD
stall_count_o  out  CNT_WIDTH  load-use bubbles inserted
flush_count_o  out  CNT_WIDTH  redirects accepted

Behaviour:
- Reset (async, active-high): state RUN, shadow counter 0, both counters 0.
- Default outputs, no event: pc_write_o=1, if_id_write_o=1, pipe_en_o=1, bubble and flushes 0.
- Outputs are combinational from state and inputs. State and counters update on the rising clk edge.
- Load-use condition lu: ex_mem_read_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- Priority per cycle: ext_hold_i > accepted redirect > lu.
- Hold (ext_hold_i=1): pc_write_o=0, if_id_write_o=0, pipe_en_o=0, no flush, no bubble.
  - Any pending redirect is deferred; the MEM instruction is frozen, so it re-presents after release.
  - The shadow counter freezes.
  - From RUN/STALL go to HOLD. SHADOW stays SHADOW.
  - HOLD returns to RUN on the first cycle with ext_hold_i=0, evaluating that cycle's events normally.
- Redirect accepted when mem_redirect_i=1, ext_hold_i=0 and state!=SHADOW:
  - Outputs: if_id_flush_o=id_ex_flush_o=ex_mem_flush_o=1, pc_write_o=1, pipe_en_o=1.
  - lu is ignored that cycle; no bubble is counted.
  - Next state SHADOW, shadow counter loaded with SHADOW_CYCLES; flush_count increments.
- SHADOW:
  - mem_redirect_i is ignored.
  - Counter decrements each non-held cycle; at the cycle it reaches 0, next state is RUN.
  - lu is still honoured inside SHADOW, with the STALL outputs and count, but the state remains SHADOW.
- Stall on lu (no hold, no accepted redirect):
  - pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, pipe_en_o=1.
  - stall_count increments. From RUN, next state is STALL.
- STALL lasts exactly one cycle, then RUN.
  - lu is re-evaluated in STALL; it normally deasserts because EX now holds the bubble.
  - If lu is still true, STALL repeats and counts again.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall or mid-shadow returns to RUN immediately. No flush is generated by reset itself.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_count_o and flush_count_o are implemented as above.
- Undefined: no counter registers; both ports are tied to 0. All other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rt_i=8, id_rs_i=8 for one cycle -> that cycle pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; state_o 1 then 0; stall_count_o=1.
- $zero and rt-unused cases:
  - ex_rt_i=0 with id_rs_i=0 -> no stall.
  - ex_rt_i=9, id_rt_i=9, id_uses_rt_i=0 -> no stall.
- Redirect and shadow:
  - mem_redirect_i=1 from RUN -> all three flushes=1 for one cycle, flush_count_o=1, state_o=2 for 3 cycles, then 0.
  - Redirect asserted again in shadow cycle 2 -> ignored, flush_count_o stays 1.
- Simultaneous redirect + lu: both true in one cycle -> flushes=1, id_ex_bubble_o=0, pc_write_o=1, stall_count_o unchanged.
- Hold:
  - ext_hold_i=1 for 4 cycles with mem_redirect_i=1 -> pipe_en_o=0, no flush, state_o=3.
  - On release -> redirect accepted that cycle.
  - Hold inside SHADOW extends SHADOW by 4 cycles.
- Saturation/reset: with CNT_WIDTH=2, 5 load-use stalls -> stall_count_o=3. Assert reset mid-SHADOW -> state_o=0 and counters 0 immediately.
